// File: rtl/pulse_rate_monitor.sv
// Heart-rate front end: synchronises and debounces a pulse input, measures
// inter-beat intervals in prescaled ticks, rejects early beats and flags loss.
module pulse_rate_monitor #(
  parameter int TICK_DIV = 4,
  parameter int DEBOUNCE = 3,
  parameter int REFRACT  = 5,
  parameter int TIMEOUT  = 20,
  parameter int IW       = 8,
  parameter int BW       = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          status_sw,
  input  logic          pulse_btn,
  output logic          beat_o,
  output logic          reject_o,
  output logic [IW-1:0] interval_o,
  output logic          interval_valid_o,
  output logic          lost_o,
  output logic [BW-1:0] beat_count_o,
  output logic          active_o
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam logic [IW-1:0] TIMEOUT_C = IW'(TIMEOUT);
  localparam logic [IW-1:0] REFRACT_C = IW'(REFRACT);

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_ARMED = 2'd1,
    S_TRACK = 2'd2,
    S_LOST  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          sw_meta_q, sw_sync_q, pb_meta_q, pb_sync_q;
  logic          db_q, db_d, db_prev_q, cand_q;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [IW-1:0] cnt_q, cnt_d, cnt_eff_s;
  logic [IW-1:0] interval_q, interval_d;
  logic [BW-1:0] count_q, count_d;
  logic          beat_q, beat_d, reject_q, reject_d, valid_q, valid_d;
  logic          lost_q, active_q, tick_s;

  // Debounced level flips only after DEBOUNCE consecutive disagreeing samples.
  always_comb begin
    db_d     = db_q;
    db_cnt_d = '0;
    if (pb_sync_q != db_q) begin
      if (db_cnt_q == DW'(DEBOUNCE - 1)) begin
        db_d     = pb_sync_q;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + DW'(1);
      end
    end else begin
      db_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_meta_q <= 1'b0;
      sw_sync_q <= 1'b0;
      pb_meta_q <= 1'b0;
      pb_sync_q <= 1'b0;
      db_q      <= 1'b0;
      db_cnt_q  <= '0;
      db_prev_q <= 1'b0;
      cand_q    <= 1'b0;
    end else begin
      sw_meta_q <= status_sw;
      sw_sync_q <= sw_meta_q;
      pb_meta_q <= pulse_btn;
      pb_sync_q <= pb_meta_q;
      db_q      <= db_d;
      db_cnt_q  <= db_cnt_d;
      db_prev_q <= db_q;
      cand_q    <= db_q & ~db_prev_q;
    end
  end

  assign tick_s    = (state_q != S_OFF) && (presc_q == PW'(TICK_DIV - 1));
  // A tick landing in the same cycle as a beat belongs to the closing interval.
  assign cnt_eff_s = (tick_s && (cnt_q < TIMEOUT_C)) ? (cnt_q + IW'(1)) : cnt_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_eff_s;
    interval_d = interval_q;
    count_d    = count_q;
    beat_d     = 1'b0;
    reject_d   = 1'b0;
    valid_d    = 1'b0;
    if (!sw_sync_q) begin
      state_d    = S_OFF;
      cnt_d      = '0;
      interval_d = '0;
      count_d    = '0;
    end else begin
      case (state_q)
        S_OFF: begin
          state_d    = S_ARMED;
          cnt_d      = '0;
          interval_d = '0;
          count_d    = '0;
        end
        S_ARMED, S_LOST: begin
          if (cand_q) begin
            state_d = S_TRACK;
            beat_d  = 1'b1;
            count_d = count_q + BW'(1);
            cnt_d   = '0;
          end else if (cnt_eff_s == TIMEOUT_C) begin
            state_d = S_LOST;
          end else begin
            state_d = state_q;
          end
        end
        S_TRACK: begin
          if (cand_q && (cnt_eff_s < REFRACT_C)) begin
            reject_d = 1'b1;
          end else if (cand_q) begin
            beat_d     = 1'b1;
            valid_d    = 1'b1;
            interval_d = cnt_eff_s;
            count_d    = count_q + BW'(1);
            cnt_d      = '0;
          end else if (cnt_eff_s == TIMEOUT_C) begin
            state_d = S_LOST;
          end else begin
            state_d = S_TRACK;
          end
        end
        default: begin
          state_d    = S_OFF;
          cnt_d      = '0;
          interval_d = '0;
          count_d    = '0;
        end
      endcase
    end
    if ((state_q == S_OFF) || (state_d == S_OFF)) begin
      presc_d = '0;
    end else if (tick_s) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_OFF;
      presc_q    <= '0;
      cnt_q      <= '0;
      interval_q <= '0;
      count_q    <= '0;
      beat_q     <= 1'b0;
      reject_q   <= 1'b0;
      valid_q    <= 1'b0;
      lost_q     <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      cnt_q      <= cnt_d;
      interval_q <= interval_d;
      count_q    <= count_d;
      beat_q     <= beat_d;
      reject_q   <= reject_d;
      valid_q    <= valid_d;
      lost_q     <= (state_d == S_LOST);
      active_q   <= (state_d != S_OFF);
    end
  end

  assign beat_o           = beat_q;
  assign reject_o         = reject_q;
  assign interval_o       = interval_q;
  assign interval_valid_o = valid_q;
  assign lost_o           = lost_q;
  assign beat_count_o     = count_q;
  assign active_o         = active_q;

endmodule
